// File: rtl/sdram_write_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_write_pkg
// Description : Shared definitions for the SDRAM write engine: SDRAM command
//               codes ({ras_n,cas_n,we_n}), write-engine state encoding,
//               default timing values and the burst address step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_write_pkg;

    // ------------------------------------------------------------------------
    // SDRAM command encodings, driven as {ras_n, cas_n, we_n}
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_CMD_NOP   = 3'b111;
    localparam logic [2:0] c_CMD_ACT   = 3'b011;
    localparam logic [2:0] c_CMD_READ  = 3'b101;
    localparam logic [2:0] c_CMD_WRITE = 3'b100;
    localparam logic [2:0] c_CMD_PRE   = 3'b010;
    localparam logic [2:0] c_CMD_AR    = 3'b001;

    // ------------------------------------------------------------------------
    // Default SDRAM timing, in clk cycles
    // ------------------------------------------------------------------------
    localparam int c_T_RCD_DEFAULT = 3;
    localparam int c_T_WR_DEFAULT  = 2;
    localparam int c_T_RP_DEFAULT  = 3;
    localparam int c_T_RFC_DEFAULT = 7;

    // Each burst writes two 16-bit beats, i.e. two column locations.
    localparam logic [21:0] c_ADDR_STEP = 22'd2;

    // SDRAM address bus with only A10 set: PRECHARGE applies to all banks.
    localparam logic [11:0] c_ADDR_PRE_ALL = 12'h400;

    // ------------------------------------------------------------------------
    // Write engine states
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_ACTIVATE     = 3'd1,
        ST_WRITE_TOP    = 3'd2,
        ST_WRITE_BOTTOM = 3'd3,
        ST_PRECHARGE    = 3'd4,
        ST_DECIDE       = 3'd5,
        ST_WAIT_DATA    = 3'd6
    } state_t;

    // Next burst start address. The full 22-bit add carries column overflow
    // into the row and row overflow into the bank, and wraps at the top.
    function automatic logic [21:0] next_burst_addr(input logic [21:0] a);
        return a + c_ADDR_STEP;
    endfunction

endpackage : sdram_write_pkg
`default_nettype wire

// File: rtl/sdram_write.sv
`default_nettype none
// ============================================================================
// Module      : sdram_write
// Description : FIFO-to-SDRAM write engine. Pops 32-bit words from a
//               first-word-fall-through FIFO and writes each one as a
//               two-beat burst (upper half first) using a full
//               ACTIVATE / WRITE / PRECHARGE-all sequence. The address
//               auto-increments by two columns per burst while en stays
//               high; latched auto-refresh requests are serviced between
//               bursts.
// Revision    : 1.0 - initial release
//
// Ports
//   clk           in   SDRAM clock, all logic on posedge
//   rst           in   synchronous active-high reset
//   en            in   controller grants this engine the SDRAM
//   address[21:0] in   start address {bank[1:0], row[11:0], column[7:0]}
//   ready         out  idle with no pending delay; able to accept en
//   auto_refresh  in   one-cycle refresh request pulse
//   writing       out  engine owns the SDRAM bus (command mux select)
//   command[2:0]  out  {ras_n, cas_n, we_n}
//   addr[11:0]    out  SDRAM address bus
//   bank[1:0]     out  SDRAM bank select
//   data_out[15:0]out  DQ write data
//   data_oe       out  DQ output enable (only during the two data beats)
//   data_mask[1:0]out  DQM, always 2'b00
//   fifo_data[31:0]in  FIFO head word, valid whenever !fifo_empty
//   fifo_empty    in   FIFO empty flag
//   fifo_rd       out  one-cycle FIFO pop strobe
// ============================================================================
module sdram_write
    import sdram_write_pkg::*;
#(
    parameter int T_RCD = c_T_RCD_DEFAULT,
    parameter int T_WR  = c_T_WR_DEFAULT,
    parameter int T_RP  = c_T_RP_DEFAULT,
    parameter int T_RFC = c_T_RFC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [21:0] address,
    output logic        ready,
    input  logic        auto_refresh,
    output logic        writing,
    output logic [2:0]  command,
    output logic [11:0] addr,
    output logic [1:0]  bank,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic [1:0]  data_mask,
    input  logic [31:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd
);

    // Delay counter reload values. The state that issues a command spends one
    // cycle itself, so a wait of N cycles reloads the counter with N-1.
    localparam logic [7:0] c_RCD_LOAD = 8'(T_RCD - 1);
    localparam logic [7:0] c_WR_LOAD  = 8'(T_WR - 1);
    localparam logic [7:0] c_RP_LOAD  = 8'(T_RP - 1);
    localparam logic [7:0] c_RFC_LOAD = 8'(T_RFC - 1);

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_delay;
    logic [21:0] r_laddress;
    logic [31:0] r_wdata;
    logic        r_lref;
    logic [2:0]  r_command;
    logic [11:0] r_addr;
    logic [1:0]  r_bank;
    logic [15:0] r_data_out;
    logic        r_data_oe;
    logic        r_writing;
    logic        r_fifo_rd;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t      w_state_next;
    logic [7:0]  w_delay_next;
    logic [21:0] w_laddress_next;
    logic [31:0] w_wdata_next;
    logic        w_lref_next;
    logic [2:0]  w_command_next;
    logic [11:0] w_addr_next;
    logic [1:0]  w_bank_next;
    logic [15:0] w_data_out_next;
    logic        w_data_oe_next;
    logic        w_writing_next;
    logic        w_fifo_rd_next;
    logic        w_ar_issue;

    // Address field views of the latched burst address.
    logic [1:0]  w_lbank;
    logic [11:0] w_lrow;
    logic [7:0]  w_lcol;

    assign w_lbank = r_laddress[21:20];
    assign w_lrow  = r_laddress[19:8];
    assign w_lcol  = r_laddress[7:0];

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // Defaults: commands and strobes are single-cycle, everything else
        // holds its value.
        w_state_next    = r_state;
        w_delay_next    = r_delay;
        w_laddress_next = r_laddress;
        w_wdata_next    = r_wdata;
        w_command_next  = c_CMD_NOP;
        w_addr_next     = r_addr;
        w_bank_next     = r_bank;
        w_data_out_next = r_data_out;
        w_data_oe_next  = 1'b0;
        w_writing_next  = r_writing;
        w_fifo_rd_next  = 1'b0;
        w_ar_issue      = 1'b0;

        if (r_delay != 8'd0) begin
            // Timing wait: NOP on the bus, state held.
            w_delay_next = r_delay - 8'd1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_writing_next = 1'b0;
                    if (en && !fifo_empty) begin
                        // The head word is consumed now; the FIFO drops it
                        // on the edge that samples fifo_rd.
                        w_fifo_rd_next  = 1'b1;
                        w_wdata_next    = fifo_data;
                        w_laddress_next = address;
                        w_writing_next  = 1'b1;
                        w_state_next    = ST_ACTIVATE;
                    end
                end

                ST_ACTIVATE: begin
                    w_command_next = c_CMD_ACT;
                    w_bank_next    = w_lbank;
                    w_addr_next    = w_lrow;
                    w_delay_next   = c_RCD_LOAD;
                    w_state_next   = ST_WRITE_TOP;
                end

                ST_WRITE_TOP: begin
                    // A10 low: no auto-precharge, the explicit PRE follows.
                    w_command_next  = c_CMD_WRITE;
                    w_addr_next     = {4'b0000, w_lcol};
                    w_data_out_next = r_wdata[31:16];
                    w_data_oe_next  = 1'b1;
                    w_state_next    = ST_WRITE_BOTTOM;
                end

                ST_WRITE_BOTTOM: begin
                    w_data_out_next = r_wdata[15:0];
                    w_data_oe_next  = 1'b1;
                    w_laddress_next = next_burst_addr(r_laddress);
                    w_delay_next    = c_WR_LOAD;
                    w_state_next    = ST_PRECHARGE;
                end

                ST_PRECHARGE: begin
                    w_command_next = c_CMD_PRE;
                    w_addr_next    = c_ADDR_PRE_ALL;
                    w_delay_next   = c_RP_LOAD;
                    w_state_next   = ST_DECIDE;
                end

                ST_DECIDE, ST_WAIT_DATA: begin
                    // Refresh takes priority even if en has dropped: a
                    // request latched while we owned the bus is ours to
                    // service before handing the bus back.
                    if (r_lref) begin
                        w_command_next = c_CMD_AR;
                        w_ar_issue     = 1'b1;
                        w_delay_next   = c_RFC_LOAD;
                        w_state_next   = ST_DECIDE;
                    end else if (!en) begin
                        w_writing_next = 1'b0;
                        w_state_next   = ST_IDLE;
                    end else if (fifo_empty) begin
                        w_state_next = ST_WAIT_DATA;
                    end else begin
                        w_fifo_rd_next = 1'b1;
                        w_wdata_next   = fifo_data;
                        w_state_next   = ST_ACTIVATE;
                    end
                end

                default: begin
                    w_writing_next = 1'b0;
                    w_state_next   = ST_IDLE;
                end
            endcase
        end

        // A new request arriving on the same cycle as the AR is kept, so it
        // gets its own refresh later rather than being absorbed.
        w_lref_next = (r_lref & ~w_ar_issue) | (auto_refresh & en);
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_delay    <= 8'd0;
            r_laddress <= 22'd0;
            r_wdata    <= 32'd0;
            r_lref     <= 1'b0;
            r_command  <= c_CMD_NOP;
            r_addr     <= 12'd0;
            r_bank     <= 2'd0;
            r_data_out <= 16'd0;
            r_data_oe  <= 1'b0;
            r_writing  <= 1'b0;
            r_fifo_rd  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_delay    <= w_delay_next;
            r_laddress <= w_laddress_next;
            r_wdata    <= w_wdata_next;
            r_lref     <= w_lref_next;
            r_command  <= w_command_next;
            r_addr     <= w_addr_next;
            r_bank     <= w_bank_next;
            r_data_out <= w_data_out_next;
            r_data_oe  <= w_data_oe_next;
            r_writing  <= w_writing_next;
            r_fifo_rd  <= w_fifo_rd_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready     = (r_state == ST_IDLE) && (r_delay == 8'd0);
    assign writing   = r_writing;
    assign command   = r_command;
    assign addr      = r_addr;
    assign bank      = r_bank;
    assign data_out  = r_data_out;
    assign data_oe   = r_data_oe;
    assign data_mask = 2'b00;
    assign fifo_rd   = r_fifo_rd;

endmodule : sdram_write
`default_nettype wire

// File: tb/tb_sdram_write.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_write
// Description : Self-checking bench for sdram_write. A FIFO model feeds the
//               engine; every pushed word queues its expected SDRAM events
//               (ACT, WRITE+upper beat, lower beat, PRE) with their required
//               spacing. A monitor on the falling edge pops and compares each
//               bus event; AUTO REFRESH is tracked by a request counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_write;

    localparam int T_RCD = 3;
    localparam int T_WR  = 2;
    localparam int T_RP  = 3;
    localparam int T_RFC = 7;

    localparam logic [2:0] c_NOP   = 3'b111;
    localparam logic [2:0] c_ACT   = 3'b011;
    localparam logic [2:0] c_WRITE = 3'b100;
    localparam logic [2:0] c_PRE   = 3'b010;
    localparam logic [2:0] c_AR    = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [21:0] address = 22'd0;
    logic        auto_refresh = 1'b0;
    logic [31:0] fifo_data = 32'd0;
    logic        fifo_empty = 1'b1;
    logic        ready;
    logic        writing;
    logic [2:0]  command;
    logic [11:0] addr;
    logic [1:0]  bank;
    logic [15:0] data_out;
    logic        data_oe;
    logic [1:0]  data_mask;
    logic        fifo_rd;

    always #5 clk = ~clk;

    sdram_write #(
        .T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .address(address), .ready(ready),
        .auto_refresh(auto_refresh), .writing(writing), .command(command),
        .addr(addr), .bank(bank), .data_out(data_out), .data_oe(data_oe),
        .data_mask(data_mask), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_rd(fifo_rd)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic        oe;
        logic [11:0] a;
        logic [11:0] amask;
        logic        chk_bank;
        logic [1:0]  bk;
        logic [15:0] d;
        int          gap;    // exact cycles since previous event, -1 = ACT rules
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fifo_q[$];
    logic [21:0] next_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pop_cyc = -100;
    int last_cyc = -100;
    logic [2:0] last_cmd = 3'b111;
    int n_pop = 0;
    int n_ref_acc = 0;     // refresh requests accepted (pulse while en)
    int n_ar = 0;          // AR commands observed
    int n_act_seen = 0;
    int n_data_seen = 0;
    int ref_now_req = 0, ref_now_done = 0;
    int ref_force_req = 0, ref_force_done = 0;
    bit ref_rand = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- rising edge: FIFO pops and refresh acceptance --------
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (fifo_rd) begin
                chk("fifo_rd_when_nonempty", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                n_pop++;
                pop_cyc = cyc;
            end
            if (!rst && auto_refresh && en) n_ref_acc++;
        end
    end

    // ---------------- falling edge: monitor, FIFO outputs, refresh drive ---
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            fifo_empty = (fifo_q.size() == 0);
            fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
            auto_refresh = 1'b0;

            if (!rst && (command != c_NOP || data_oe)) begin
                chk("writing_during_event", 32'(writing), 32'd1);
                if (command == c_AR) begin
                    chk("ar_requested", 32'(n_ref_acc > n_ar), 32'd1);
                    chk("ar_follows_pre", 32'(last_cmd), 32'(c_PRE));
                    chk("ar_gap_after_pre", 32'(cyc - last_cyc), 32'(T_RP));
                    chk("ar_no_oe", 32'(data_oe), 32'd0);
                    n_ar++;
                end else if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: cmd=%b oe=%b addr=0x%0h (t=%0t)",
                             command, data_oe, addr, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd", 32'(command), 32'(e.cmd));
                    chk("data_oe", 32'(data_oe), 32'(e.oe));
                    if (e.amask != 12'd0)
                        chk("addr", 32'(addr & e.amask), 32'(e.a));
                    if (e.chk_bank) chk("bank", 32'(bank), 32'(e.bk));
                    if (e.oe) chk("dq", 32'(data_out), 32'(e.d));
                    if (e.gap >= 0) begin
                        chk("gap", 32'(cyc - last_cyc), 32'(e.gap));
                    end else begin
                        chk("act_follows_pop", 32'(cyc - pop_cyc), 32'd0);
                        if (last_cmd == c_PRE)
                            chk("act_after_pre_trp", 32'(cyc - last_cyc >= T_RP + 1), 32'd1);
                        if (last_cmd == c_AR)
                            chk("act_after_ar_trfc", 32'(cyc - last_cyc >= T_RFC + 1), 32'd1);
                    end
                    chk("dqm", 32'(data_mask), 32'd0);
                    if (command == c_ACT) n_act_seen++;
                    if (command == c_NOP) n_data_seen++;
                    if (command == c_WRITE) begin
                        // refresh pulse lands on the lower-beat cycle
                        if (ref_force_req != ref_force_done) begin
                            ref_force_done++;
                            auto_refresh = 1'b1;
                        end else if (ref_rand && $urandom_range(2) == 0) begin
                            auto_refresh = 1'b1;
                        end
                    end
                end
                last_cyc = cyc;
                last_cmd = command;
            end

            if (ref_now_req != ref_now_done) begin
                ref_now_done++;
                auto_refresh = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_exp(input logic [21:0] a, input logic [31:0] w, input int upto);
        exp_t e;
        e = '{cmd: c_ACT, oe: 1'b0, a: a[19:8], amask: 12'hFFF, chk_bank: 1'b1,
              bk: a[21:20], d: 16'd0, gap: -1};
        exp_q.push_back(e);
        if (upto < 2) return;
        e = '{cmd: c_WRITE, oe: 1'b1, a: {4'b0000, a[7:0]}, amask: 12'hFFF,
              chk_bank: 1'b1, bk: a[21:20], d: w[31:16], gap: T_RCD};
        exp_q.push_back(e);
        e = '{cmd: c_NOP, oe: 1'b1, a: 12'd0, amask: 12'd0, chk_bank: 1'b0,
              bk: 2'd0, d: w[15:0], gap: 1};
        exp_q.push_back(e);
        e = '{cmd: c_PRE, oe: 1'b0, a: 12'h400, amask: 12'h400, chk_bank: 1'b0,
              bk: 2'd0, d: 16'd0, gap: T_WR};
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] w);
        push_exp(next_addr, w, 4);
        next_addr = next_addr + 22'd2;
        fifo_q.push_back(w);
    endtask

    task automatic sess_start(input logic [21:0] a);
        @(negedge clk);
        address   = a;
        next_addr = a;
        en        = 1'b1;
    endtask

    task automatic wait_drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(ready), 32'd1);
    endtask

    task automatic sess_end(input string nm);
        wait_drain({nm, "_drain"});
        @(negedge clk);
        en = 1'b0;
        wait_ready({nm, "_ready"});
        @(negedge clk);
        chk({nm, "_writing_low"}, 32'(writing), 32'd0);
        chk({nm, "_refresh_served"}, 32'(n_ref_acc - n_ar), 32'd0);
        chk({nm, "_fifo_drained"}, 32'(fifo_q.size()), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int p0, a0, k, nw, gap;
        logic [21:0] sa;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_command", 32'(command), 32'(c_NOP));
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_bank", 32'(bank), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        chk("rst_writing", 32'(writing), 32'd0);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single burst
        sess_start(22'h000010);
        push_word(32'hDEADBEEF);
        sess_end("t1");

        // 2: column 0xFE rolls into next row
        p0 = n_pop;
        sess_start(22'h0001FE);
        push_word(32'hA5A50F0F);
        push_word(32'h3C3C9696);
        sess_end("t2");
        chk("t2_pop_count", 32'(n_pop - p0), 32'd2);

        // 3: FIFO runs dry between words
        sess_start(22'h123456);
        push_word(32'h01020304);
        wait_drain("t3_first_drain");
        repeat (10) @(negedge clk);
        chk("t3_wait_cmd_nop", 32'(command), 32'(c_NOP));
        chk("t3_wait_writing", 32'(writing), 32'd1);
        chk("t3_wait_not_ready", 32'(ready), 32'd0);
        push_word(32'h12345678);
        sess_end("t3");

        // 4: refresh during a burst, then a refresh pulse with en low
        a0 = n_ar;
        sess_start(22'h200000);
        ref_force_req++;
        push_word(32'hCAFEF00D);
        push_word(32'h0BADC0DE);
        sess_end("t4");
        chk("t4_one_ar", 32'(n_ar - a0), 32'd1);
        a0 = n_ar;
        ref_now_req++;
        repeat (3) @(negedge clk);
        sess_start(22'h000100);
        push_word(32'h55AA55AA);
        sess_end("t4b");
        chk("t4b_no_ar_when_disabled", 32'(n_ar - a0), 32'd0);

        // 5: en drops during the lower beat
        p0 = n_pop;
        sess_start(22'h000040);
        push_word(32'h11112222);
        fifo_q.push_back(32'h33334444);
        fifo_q.push_back(32'h55556666);
        k = n_data_seen;
        for (int i = 0; i < 100 && n_data_seen == k; i++) @(negedge clk);
        chk("t5_lower_beat_seen", 32'(n_data_seen - k), 32'd1);
        en = 1'b0;
        wait_ready("t5_ready");
        repeat (10) @(negedge clk);
        chk("t5_single_pop", 32'(n_pop - p0), 32'd1);
        chk("t5_fifo_left", 32'(fifo_q.size()), 32'd2);
        chk("t5_drain", 32'(exp_q.size()), 32'd0);
        fifo_q.delete();
        repeat (2) @(negedge clk);

        // 6: reset during the ACT-to-WRITE delay
        sess_start(22'h0ABCDE);
        push_exp(22'h0ABCDE, 32'h9999AAAA, 1);
        fifo_q.push_back(32'h9999AAAA);
        k = n_act_seen;
        for (int i = 0; i < 50 && n_act_seen == k; i++) @(negedge clk);
        chk("t6_act_seen", 32'(n_act_seen - k), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_cmd_nop", 32'(command), 32'(c_NOP));
        chk("t6_oe_low", 32'(data_oe), 32'd0);
        chk("t6_writing_low", 32'(writing), 32'd0);
        chk("t6_ready", 32'(ready), 32'd1);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fifo_q.delete();
        repeat (5) @(negedge clk);
        chk("t6_no_more_events", 32'(exp_q.size()), 32'd0);

        // randomized sessions
        ref_rand = 1'b1;
        for (int s = 0; s < 8; s++) begin
            case ($urandom_range(3))
                0: sa = 22'h3FFFFA;
                1: sa = {2'($urandom), 12'($urandom), 8'hFA};
                default: sa = 22'($urandom);
            endcase
            nw = $urandom_range(6, 1);
            sess_start(sa);
            for (int w = 0; w < nw; w++) begin
                push_word($urandom);
                gap = ($urandom_range(2) == 0) ? 0 : $urandom_range(25);
                repeat (gap) @(negedge clk);
            end
            sess_end("rand");
            repeat ($urandom_range(4)) @(negedge clk);
        end

        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sdram_write
`default_nettype wire
